vga_fb_mem_responder: RTL

//  Bus-slave end of the burst read/write protocol that the VGA bus master initiates.

---
 rtl/vga_fb_mem_responder_pkg.sv | 37 +++
 rtl/vga_fb_mem_responder_fb_ram.sv | 37 +++
 rtl/vga_fb_mem_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/vga_fb_mem_responder_pkg.sv
// Shared definitions for the VGA framebuffer bus responder.
// Covers ctrl-word bit positions, burst codes and FSM state encodings.
package vga_fb_mem_responder_pkg;

    localparam int CTRL_WAIT     = 0;
    localparam int CTRL_VALID    = 1;
    localparam int CTRL_WR       = 3;
    localparam int CTRL_BURST_LO = 4;
    localparam int CTRL_BURST_HI = 5;

    localparam logic [1:0] BURST_1  = 2'b00;
    localparam logic [1:0] BURST_16 = 2'b01;
    localparam logic [1:0] BURST_8  = 2'b10;
    localparam logic [1:0] BURST_4  = 2'b11;

    // Five bits so a full 16-beat burst length fits.
    localparam int BEAT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RD   = 2'd2,
        ST_WR   = 2'd3
    } state_e;

    function automatic logic [BEAT_W-1:0] burst_len(input logic [1:0] code);
        logic [BEAT_W-1:0] len;
        case (code)
            BURST_1:  len = 5'd1;
            BURST_16: len = 5'd16;
            BURST_8:  len = 5'd8;
            default:  len = 5'd4;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/vga_fb_mem_responder_fb_ram.sv
// Single-port framebuffer RAM with a one-cycle registered read.
// The read register clears whenever no read is issued, so it can drive the bus directly.
module vga_fb_mem_responder_fb_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/vga_fb_mem_responder.sv
// Bus-slave responder: latches address/ctrl on select, inserts wait states,
// then serves single or burst reads/writes from the framebuffer RAM.
module vga_fb_mem_responder
    import vga_fb_mem_responder_pkg::*;
#(
    parameter int BUS_WIDTH   = 32,
    parameter int CTRL_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  bus_slave_en,
    input  logic [BUS_WIDTH-1:0]  bus_in,
    input  logic [CTRL_WIDTH-1:0] ctrl_in,
    output logic [BUS_WIDTH-1:0]  bus_out,
    output logic [CTRL_WIDTH-1:0] ctrl_out,
    output logic                  busy
);

    localparam int WCNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [BEAT_W-1:0]       len_q, len_d;
    logic [BEAT_W-1:0]       beat_q, beat_d;
    logic [WCNT_W-1:0]       wcnt_q, wcnt_d;
    logic                    wr_q, wr_d;
    logic [CTRL_WIDTH-1:0]   ctrl_out_q, ctrl_out_d;
    logic                    busy_q, busy_d;

    logic                    last_beat;
    logic                    ram_we;
    logic                    ram_re;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    logic unused_bits;
    assign unused_bits = ^{bus_in[BUS_WIDTH-1:DATA_WIDTH], ctrl_in[CTRL_WIDTH-1:CTRL_BURST_HI+1],
                           ctrl_in[CTRL_WR-1:0]};

    assign last_beat = (beat_q == (len_q - 5'd1));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        beat_d   = beat_q;
        wcnt_d   = wcnt_q;
        wr_d     = wr_q;
        ram_we   = 1'b0;
        ram_re   = 1'b0;
        ram_addr = addr_q + ADDR_WIDTH'(beat_q);

        case (state_q)
            ST_IDLE: begin
                if (bus_slave_en) begin
                    addr_d  = bus_in[ADDR_WIDTH-1:0];
                    len_d   = burst_len(ctrl_in[CTRL_BURST_HI:CTRL_BURST_LO]);
                    wr_d    = ctrl_in[CTRL_WR];
                    wcnt_d  = '0;
                    beat_d  = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wcnt_q == WCNT_W'(WAIT_CYCLES - 1)) begin
                    wcnt_d  = '0;
                    beat_d  = '0;
                    // Prefetch the first read word so beat 0 has data on the bus.
                    ram_re  = !wr_q;
                    state_d = wr_q ? ST_WR : ST_RD;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ST_RD: begin
                // Read one word ahead so every beat is back-to-back.
                ram_addr = addr_q + ADDR_WIDTH'(beat_q) + ADDR_WIDTH'(1);
                ram_re   = !last_beat;
                if (last_beat) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_d = beat_q + 5'd1;
                end
            end
            ST_WR: begin
                ram_we = 1'b1;
                if (last_beat) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_d = beat_q + 5'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        ctrl_out_d             = '0;
        ctrl_out_d[CTRL_WAIT]  = (state_d == ST_WAIT);
        ctrl_out_d[CTRL_VALID] = (state_d == ST_RD) || (state_d == ST_WR);
        busy_d                 = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            len_q      <= '0;
            beat_q     <= '0;
            wcnt_q     <= '0;
            wr_q       <= 1'b0;
            ctrl_out_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            beat_q     <= beat_d;
            wcnt_q     <= wcnt_d;
            wr_q       <= wr_d;
            ctrl_out_q <= ctrl_out_d;
            busy_q     <= busy_d;
        end
    end

    vga_fb_mem_responder_fb_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fb_ram (
        .clk    (clk),
        .reset_L(reset_L),
        .we_i   (ram_we),
        .re_i   (ram_re),
        .addr_i (ram_addr),
        .wdata_i(bus_in[DATA_WIDTH-1:0]),
        .rdata_o(ram_rdata)
    );

    assign bus_out  = {{(BUS_WIDTH-DATA_WIDTH){1'b0}}, ram_rdata};
    assign ctrl_out = ctrl_out_q;
    assign busy     = busy_q;

endmodule
